wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and general-purpose register file for the five-stage pipeline. Consumes the MEM/WB pipeline register outputs, selects the write-back value (ALU result or memory load data), and commits it to a 32 x 32-bit register file. Serves the ID stage with two combinational read ports that include write-through bypass. Also exports the selected write-back value for the EX-stage forwarding network.

## Interface
Parameters:
- none; widths are fixed: 32-bit data, 5-bit register address, 32 registers.

Ports:
- Clk  in  1  system clock; all register writes occur on the rising edge.
- Clrn  in  1  asynchronous, active-low reset; clears every register.
- wWreg  in  1  write enable from MEM/WB.
- wReg2reg  in  1  write-back source select: 1 = ALU result wC, 0 = memory data wD.
- wD  in  32  memory load data from MEM/WB.
- wC  in  32  ALU result from MEM/WB.
- wRd  in  5  destination register from MEM/WB.
- Rs  in  5  ID read address A.
- Rt  in  5  ID read address B.
- DbgA  in  5  debug/observation read address.
- Qa  out  32  read data for Rs.
- Qb  out  32  read data for Rt.
- DbgQ  out  32  read data for DbgA; no bypass.
- WbData  out  32  selected write-back value, to the forwarding mux in EX.
- WbWe  out  1  effective write strobe: wWreg & (wRd != 0).

## Operation
- WbData = wReg2reg ? wC : wD. Purely combinational, always valid regardless of wWreg.
- WbWe = wWreg and wRd nonzero. Writes to r0 are discarded. r0 reads 0 on every port.
- Storage holds r1..r31 only; r0 is not stored.
- Write: on posedge Clk with Clrn=1 and WbWe=1, reg[wRd] <= WbData. No other register changes.
- Read ports Qa/Qb are combinational on Rs/Rt.
  - If WbWe=1 and the address equals wRd, the port returns WbData (write-through: the ID stage sees the value being committed in the same cycle).
  - Otherwise the port returns reg[addr], or 0 for addr 0.
- Rs == Rt: both ports return the identical value, including under bypass.
- DbgQ returns stored reg[DbgA] (0 for DbgA=0), without bypass. The testbench uses it to inspect architectural state.
- There is no stall or enable input. Pipeline freezing is handled upstream: MEM/WB en low holds wWreg, and a held write simply rewrites the same value.

## Timing
- Reset: Clrn low asynchronously forces r1..r31 to 0 immediately, without waiting for Clk.
  - While Clrn=0:
    - Qa, Qb and DbgQ read 0.
    - Bypass is suppressed.
    - Clk edges perform no write.
  - WbData and WbWe remain combinational functions of their inputs.
- Reset release: the first write takes effect on the first rising Clk edge with Clrn=1.
- Write latency: 1 edge. The value is visible on DbgQ after the edge, and on Qa/Qb in the same cycle via bypass.
- Read latency: 0 cycles (combinational).
- Clrn deasserting at the same instant as a rising Clk edge: the write is not performed; reset wins.
- Back-to-back writes to the same register on consecutive cycles: each edge commits its own WbData, so the last write wins.
- X on wReg2reg/wD/wC with WbWe=0 must not corrupt state.

## Test plan
- Reset:
  - Stimulus: preload r5=0x12345678, then pulse Clrn low mid-cycle with no Clk edge.
  - Required: DbgQ(5)=0 immediately, and Qa(Rs=5)=0 while Clrn is low.
- Source select:
  - Stimulus: wWreg=1, wRd=3, wC=0xAAAA0001, wD=0x5555FFFF, wReg2reg=1, one edge; then wRd=4, wReg2reg=0, one edge.
  - Required: DbgQ(3)=0xAAAA0001, DbgQ(4)=0x5555FFFF.
- r0 protection:
  - Stimulus: wWreg=1, wRd=0, wC=0xFFFFFFFF, wReg2reg=1.
  - Required: WbWe=0; Qa(Rs=0)=0 before and after the edge; DbgQ(0)=0.
- Bypass:
  - Stimulus: r7=0x11111111 stored; drive wWreg=1, wRd=7, wC=0x22222222, Rs=7, Rt=7.
  - Required: Qa=Qb=0x22222222 before the edge while DbgQ(7)=0x11111111; after the edge DbgQ(7)=0x22222222.
- Write disabled:
  - Stimulus: wWreg=0, wRd=9, wC=0xDEADBEEF over 3 edges, Rs=9.
  - Required: Qa and DbgQ(9) unchanged, and WbData=0xDEADBEEF.
- Full sweep:
  - Stimulus: write reg[i]=i*0x01010101 for i=1..31 on consecutive edges.
  - Required: readback of every register via Rs, Rt and DbgA matches, and r0 reads 0.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and 32 x 32-bit general-purpose register file.
//   Selects the write-back value (ALU result or load data), commits it on the
//   rising clock edge, and serves two combinational read ports with
//   write-through bypass plus one un-bypassed debug read port.
// Ports:
//   Clk, Clrn          clock; asynchronous active-low reset clearing r1..r31
//   wWreg, wReg2reg    MEM/WB write enable and source select (1 = wC, 0 = wD)
//   wD, wC, wRd        MEM/WB load data, ALU result, destination register
//   Rs, Rt -> Qa, Qb   ID-stage read ports (bypassed)
//   DbgA -> DbgQ       observation read port (stored state only)
//   WbData, WbWe       selected write-back value and effective write strobe
module wb_regfile (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        wWreg,
  input  logic        wReg2reg,
  input  logic [31:0] wD,
  input  logic [31:0] wC,
  input  logic [4:0]  wRd,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  DbgA,
  output logic [31:0] Qa,
  output logic [31:0] Qb,
  output logic [31:0] DbgQ,
  output logic [31:0] WbData,
  output logic        WbWe
);

  // r0 is hard-wired to zero, so only r1..r31 are stored.
  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];

  logic [31:0] qa_st, qb_st, dbg_st;

  always_comb begin
    WbData = wReg2reg ? wC : wD;
    WbWe   = wWreg && (wRd != '0);
  end

  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 1; i < 32; i++) begin
      if (WbWe && (wRd == 5'(i))) regs_d[i] = WbData;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int unsigned i = 1; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    qa_st  = (Rs   == '0) ? '0 : regs_q[Rs];
    qb_st  = (Rt   == '0) ? '0 : regs_q[Rt];
    dbg_st = (DbgA == '0) ? '0 : regs_q[DbgA];
  end

  // Bypass is gated by Clrn: during reset the pending write will not commit,
  // so the read ports must not advertise it.
  always_comb begin
    Qa   = qa_st;
    Qb   = qb_st;
    DbgQ = dbg_st;
    if (!Clrn) begin
      Qa = '0;
      Qb = '0;
    end else begin
      if (WbWe && (Rs == wRd)) Qa = WbData;
      if (WbWe && (Rt == wRd)) Qb = WbData;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: self-checking bench for wb_regfile. A reference register
// model produces expected values, which are queued when stimulus is driven
// and popped/compared when the DUT outputs are sampled.
module tb_wb_regfile;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic        wWreg, wReg2reg;
  logic [31:0] wD, wC;
  logic [4:0]  wRd, Rs, Rt, DbgA;
  logic [31:0] Qa, Qb, DbgQ, WbData;
  logic        WbWe;

  wb_regfile dut (
    .Clk(Clk), .Clrn(Clrn), .wWreg(wWreg), .wReg2reg(wReg2reg),
    .wD(wD), .wC(wC), .wRd(wRd), .Rs(Rs), .Rt(Rt), .DbgA(DbgA),
    .Qa(Qa), .Qb(Qb), .DbgQ(DbgQ), .WbData(WbData), .WbWe(WbWe)
  );

  always #5 Clk = ~Clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [31:0] mdl [0:31];
  logic [31:0] sb_exp [$];
  string       sb_tag [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    if (sb_exp.size() == 0) begin
      check("sb_empty", got, ~got);
    end else begin
      check(sb_tag.pop_front(), got, sb_exp.pop_front());
    end
  endtask

  // One write-back cycle; model commits only on an effective write.
  task automatic wb_cycle(input logic we, input logic [4:0] rd, input logic sel,
                          input logic [31:0] c, input logic [31:0] d);
    wWreg = we; wRd = rd; wReg2reg = sel; wC = c; wD = d;
    @(posedge Clk);
    if (Clrn && we && rd != 5'd0) mdl[rd] = sel ? c : d;
    #1;
  endtask

  // Read a register on all three ports with no write pending.
  task automatic read_all(input logic [4:0] a, input string tag);
    wWreg = 1'b0; Rs = a; Rt = a; DbgA = a;
    sb_push({tag, "_qa"}, mdl[a]);
    sb_push({tag, "_qb"}, mdl[a]);
    sb_push({tag, "_dbg"}, mdl[a]);
    #1;
    sb_pop(Qa); sb_pop(Qb); sb_pop(DbgQ);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    Clrn = 1'b0; wWreg = 1'b0; wReg2reg = 1'b0; wD = '0; wC = '0;
    wRd = '0; Rs = 5'd5; Rt = 5'd5; DbgA = 5'd5;
    #2;
    sb_push("rst_init_dbg", 32'h0); sb_push("rst_init_qa", 32'h0);
    sb_pop(DbgQ); sb_pop(Qa);
    #10; Clrn = 1'b1;           // release mid-cycle
    @(posedge Clk); #1;

    // Reset: preload r5 then assert Clrn between edges
    wb_cycle(1'b1, 5'd5, 1'b1, 32'h1234_5678, 32'h0);
    read_all(5'd5, "preload_r5");
    wWreg = 1'b1; wRd = 5'd5; wReg2reg = 1'b1; wC = 32'hCAFE_0005;
    Rs = 5'd5; Rt = 5'd5; DbgA = 5'd5;
    #1; Clrn = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    sb_push("rst_dbg5", 32'h0); sb_push("rst_qa_nobypass", 32'h0);
    sb_push("rst_wbdata", 32'hCAFE_0005); sb_push("rst_wbwe", 32'h1);
    #1;
    sb_pop(DbgQ); sb_pop(Qa); sb_pop(WbData); sb_pop({31'b0, WbWe});
    @(posedge Clk); #1;         // edge during reset must not write
    sb_push("rst_edge_dbg5", 32'h0); sb_pop(DbgQ);
    #2; Clrn = 1'b1;
    @(negedge Clk);

    // Source select
    wb_cycle(1'b1, 5'd3, 1'b1, 32'hAAAA_0001, 32'h5555_FFFF);
    wb_cycle(1'b1, 5'd4, 1'b0, 32'hAAAA_0001, 32'h5555_FFFF);
    read_all(5'd3, "sel_alu_r3");
    read_all(5'd4, "sel_mem_r4");

    // r0 protection
    wWreg = 1'b1; wRd = 5'd0; wReg2reg = 1'b1; wC = 32'hFFFF_FFFF; Rs = 5'd0; DbgA = 5'd0;
    sb_push("r0_wbwe", 32'h0); sb_push("r0_qa_pre", 32'h0);
    #1; sb_pop({31'b0, WbWe}); sb_pop(Qa);
    @(posedge Clk); #1;
    sb_push("r0_qa_post", 32'h0); sb_push("r0_dbg_post", 32'h0);
    sb_pop(Qa); sb_pop(DbgQ);

    // Bypass
    wb_cycle(1'b1, 5'd7, 1'b1, 32'h1111_1111, 32'h0);
    wWreg = 1'b1; wRd = 5'd7; wReg2reg = 1'b1; wC = 32'h2222_2222;
    Rs = 5'd7; Rt = 5'd7; DbgA = 5'd7;
    sb_push("byp_qa", 32'h2222_2222); sb_push("byp_qb", 32'h2222_2222);
    sb_push("byp_dbg_old", mdl[7]);
    #1; sb_pop(Qa); sb_pop(Qb); sb_pop(DbgQ);
    @(posedge Clk); mdl[7] = 32'h2222_2222; #1;
    wWreg = 1'b0;
    sb_push("byp_dbg_new", 32'h2222_2222); #1; sb_pop(DbgQ);

    // Write disabled
    wb_cycle(1'b1, 5'd9, 1'b0, 32'h0, 32'h0000_0909);
    Rs = 5'd9; DbgA = 5'd9;
    for (int k = 0; k < 3; k++) wb_cycle(1'b0, 5'd9, 1'b1, 32'hDEAD_BEEF, 32'h0);
    sb_push("wdis_qa", mdl[9]); sb_push("wdis_dbg", mdl[9]);
    sb_push("wdis_wbdata", 32'hDEAD_BEEF);
    sb_pop(Qa); sb_pop(DbgQ); sb_pop(WbData);

    // Unknown data with write disabled must not disturb state
    wWreg = 1'b0; wRd = 5'd9; wReg2reg = 1'bx; wC = 'x; wD = 'x;
    @(posedge Clk); #1;
    read_all(5'd9, "x_nowrite_r9");

    // Back-to-back writes to one register: last wins
    wb_cycle(1'b1, 5'd10, 1'b1, 32'h0000_0A01, 32'h0);
    wb_cycle(1'b1, 5'd10, 1'b0, 32'h0, 32'h0000_0A02);
    read_all(5'd10, "b2b_r10");

    // Full sweep
    for (int i = 1; i < 32; i++) wb_cycle(1'b1, 5'(i), 1'b1, 32'(i) * 32'h0101_0101, 32'h0);
    for (int i = 0; i < 32; i++) begin
      sb_push("sweep_model", 32'(i) * 32'h0101_0101);
      sb_pop(mdl[i]);
      read_all(5'(i), $sformatf("sweep_r%0d", i));
    end
    // Split-address read: Rs and Rt select different registers
    Rs = 5'd17; Rt = 5'd30; wWreg = 1'b0;
    sb_push("split_qa", mdl[17]); sb_push("split_qb", mdl[30]);
    #1; sb_pop(Qa); sb_pop(Qb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
